// File: rtl/if_fetch.sv
// ---------------------------------------------------------------------------
// if_fetch -- instruction fetch stage with IF/ID pipeline register.
//
// Fetches one instruction per cycle from a level-request instruction memory.
// The fetched instruction is written into the IF/ID register. If decode stalls
// while a word is being acknowledged, that word is parked in a skid register.
// The unit then holds (no request) until decode frees up and the skid word
// drains into IF/ID.
//
// Optional feature: define IF_FETCH_STALL_CNT_EN to build a saturating
// counter of fetch-stall cycles on stall_cnt_o. Without the macro,
// stall_cnt_o is tied to 0.
//
// Ports
//   clk_i        in   1   clock, rising edge
//   rst_i        in   1   asynchronous active-low reset
//   start_i      in   1   run enable; low keeps/returns the unit to idle
//   pc_i         in  32   current PC from the PC register
//   flush_i      in   1   branch/jump taken: drop fetch, skid and IF/ID
//   id_stall_i   in   1   decode hazard; IF/ID must hold
//   mem_req_o    out  1   instruction read request (level)
//   mem_addr_o   out 32   read address (= pc_i)
//   mem_ack_i    in   1   read data valid for mem_addr_o
//   mem_data_i   in  32   instruction word
//   stall_o      out  1   PC hold (PC register select)
//   inst_o       out 32   IF/ID instruction
//   pc_o         out 32   IF/ID PC of inst_o
//   valid_o      out  1   IF/ID holds a real instruction
//   stall_cnt_o  out 32   fetch stall cycle count (0 unless macro defined)
//   dbg_state_o  out  2   FSM state (0 IDLE, 1 FETCH, 2 HOLD)
//
// Memory handshake: mem_req_o is a level held high for the whole FETCH
// state. A transfer completes on a rising edge where mem_req_o=1 and
// mem_ack_i=1. mem_data_i is sampled on that edge. mem_ack_i is ignored
// whenever mem_req_o=0. There is no outstanding-request state: the address
// is simply pc_i, so dropping the request (flush, reset, idle) leaves
// nothing pending.
// ---------------------------------------------------------------------------
module if_fetch (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] pc_i,
  input  logic        flush_i,
  input  logic        id_stall_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_data_i,
  output logic        stall_o,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  output logic        valid_o,
  output logic [31:0] stall_cnt_o,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [31:0] r_inst;
  logic [31:0] r_pc;
  logic        r_valid;
  logic [31:0] r_skid_inst;
  logic [31:0] r_skid_pc;

  logic        w_mem_req;
  logic        w_stall;
  logic        w_load_fetch;  // memory word goes straight into IF/ID
  logic        w_load_skid;   // memory word parked while decode stalls
  logic        w_drain;       // skid word moves into IF/ID

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and combinational outputs
  always_comb begin
    w_next       = r_state;
    w_mem_req    = 1'b0;
    w_stall      = 1'b0;
    w_load_fetch = 1'b0;
    w_load_skid  = 1'b0;
    w_drain      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start_i) w_next = S_FETCH;
      end
      S_FETCH: begin
        w_mem_req = 1'b1;
        if (mem_ack_i) begin
          if (id_stall_i) begin
            w_load_skid = 1'b1;
            w_next      = S_HOLD;   // drain must finish even if start_i fell
          end else begin
            w_load_fetch = 1'b1;
            w_next       = start_i ? S_FETCH : S_IDLE;
          end
        end else begin
          w_stall = 1'b1;
          w_next  = start_i ? S_FETCH : S_IDLE;
        end
      end
      S_HOLD: begin
        w_stall = 1'b1;
        if (!id_stall_i) begin
          w_drain = 1'b1;
          w_next  = start_i ? S_FETCH : S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase

    // Flush wins over everything, including a decode stall: the PC register
    // must be free to load the branch target, so stall_o drops as well.
    if (flush_i) begin
      w_stall      = 1'b0;
      w_load_fetch = 1'b0;
      w_load_skid  = 1'b0;
      w_drain      = 1'b0;
      w_next       = start_i ? S_FETCH : S_IDLE;
    end
  end

  // IF/ID and skid registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_inst      <= 32'h0;
      r_pc        <= 32'h0;
      r_valid     <= 1'b0;
      r_skid_inst <= 32'h0;
      r_skid_pc   <= 32'h0;
    end else if (flush_i) begin
      r_inst      <= 32'h0;       // NOP
      r_pc        <= 32'h0;
      r_valid     <= 1'b0;
      r_skid_inst <= 32'h0;
      r_skid_pc   <= 32'h0;
    end else if (w_load_fetch) begin
      r_inst  <= mem_data_i;
      r_pc    <= pc_i;
      r_valid <= 1'b1;
    end else if (w_load_skid) begin
      r_skid_inst <= mem_data_i;
      r_skid_pc   <= pc_i;
    end else if (w_drain) begin
      r_inst  <= r_skid_inst;
      r_pc    <= r_skid_pc;
      r_valid <= 1'b1;
    end
  end

`ifdef IF_FETCH_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  // Counts edges with the PC held; saturates and is untouched by flush.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_stall_cnt <= 32'h0;
    end else if (w_stall && (r_state != S_IDLE) && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
`else
  assign stall_cnt_o = 32'h0;
`endif

  assign mem_req_o   = w_mem_req;
  assign mem_addr_o  = pc_i;
  assign stall_o     = w_stall;
  assign inst_o      = r_inst;
  assign pc_o        = r_pc;
  assign valid_o     = r_valid;
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_if_fetch.sv
// ---------------------------------------------------------------------------
// tb_if_fetch -- bench for if_fetch.
// Driver issues one stimulus vector per cycle shortly after the rising edge.
// At the same time, a transaction-level reference model pushes the expected
// outputs for that cycle into exp_q. A monitor on the falling edge pops each
// record and compares it with the DUT outputs.
// ---------------------------------------------------------------------------
module tb_if_fetch;

  localparam int W = 131;

  // ---------------- clock / reset ----------------
  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] pc;
  logic        flush;
  logic        id_stall;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_data;
  logic        stall;
  logic [31:0] inst;
  logic [31:0] pc_out;
  logic        valid;
  logic [31:0] stall_cnt;
  logic [1:0]  dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  if_fetch dut (
    .clk_i       (clk),
    .rst_i       (rst_n),
    .start_i     (start),
    .pc_i        (pc),
    .flush_i     (flush),
    .id_stall_i  (id_stall),
    .mem_req_o   (mem_req),
    .mem_addr_o  (mem_addr),
    .mem_ack_i   (mem_ack),
    .mem_data_i  (mem_data),
    .stall_o     (stall),
    .inst_o      (inst),
    .pc_o        (pc_out),
    .valid_o     (valid),
    .stall_cnt_o (stall_cnt),
    .dbg_state_o (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Mode of the fetch unit as seen from outside: not running, requesting,
  // or waiting for decode with a parked word.
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_PARK = 2;

  int          m_mode;
  logic [31:0] m_inst, m_pc, m_park_inst, m_park_pc;
  logic        m_valid;
  logic [31:0] m_cnt;

  task automatic model_reset();
    m_mode      = M_IDLE;
    m_inst      = 0;
    m_pc        = 0;
    m_valid     = 0;
    m_park_inst = 0;
    m_park_pc   = 0;
    m_cnt       = 0;
  endtask

  task automatic model_step(input bit st, input bit fl, input bit ids, input bit ak,
                            input logic [31:0] p, input logic [31:0] d);
    bit          req;
    bit          got;
    bit          hold_pc;
    logic [31:0] cnt_exp;
    req     = (m_mode == M_RUN);
    got     = req && ak;
    hold_pc = !fl && ((req && !got) || (m_mode == M_PARK));
`ifdef IF_FETCH_STALL_CNT_EN
    cnt_exp = m_cnt;
`else
    cnt_exp = 32'h0;
`endif
    exp_q.push_back({req, p, hold_pc, m_valid, m_inst, m_pc, cnt_exp});

    if (hold_pc && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;

    if (fl) begin
      m_inst = 0; m_pc = 0; m_valid = 0; m_park_inst = 0; m_park_pc = 0;
      m_mode = st ? M_RUN : M_IDLE;
    end else if (m_mode == M_IDLE) begin
      if (st) m_mode = M_RUN;
    end else if (m_mode == M_RUN) begin
      if (got && ids) begin
        m_park_inst = d; m_park_pc = p; m_mode = M_PARK;
      end else begin
        if (got) begin
          m_inst = d; m_pc = p; m_valid = 1;
        end
        if (!st) m_mode = M_IDLE;
      end
    end else begin
      if (!ids) begin
        m_inst = m_park_inst; m_pc = m_park_pc; m_valid = 1;
        m_mode = st ? M_RUN : M_IDLE;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input bit st, input bit fl, input bit ids, input bit ak,
                       input logic [31:0] p, input logic [31:0] d);
    @(posedge clk);
    #1;
    start = st; flush = fl; id_stall = ids; mem_ack = ak; pc = p; mem_data = d;
    model_step(st, fl, ids, ak, p, d);
  endtask

  // Asserts reset between edges (after the monitor has drained), checks the
  // asynchronous clear, then releases with start low.
  task automatic do_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst inst_o",      inst,           32'h0);
    check("rst pc_o",        pc_out,         32'h0);
    check("rst valid_o",     {31'h0, valid}, 32'h0);
    check("rst mem_req_o",   {31'h0, mem_req}, 32'h0);
    check("rst stall_o",     {31'h0, stall}, 32'h0);
    check("rst stall_cnt_o", stall_cnt,      32'h0);
    @(posedge clk);
    #1;
    start = 0; flush = 0; id_stall = 0; mem_ack = 0;
    rst_n = 1'b1;
    model_reset();
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [W-1:0] r;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        r = exp_q.pop_front();
        check("mem_req_o",   {31'h0, mem_req}, {31'h0, r[130]});
        check("mem_addr_o",  mem_addr,         r[129:98]);
        check("stall_o",     {31'h0, stall},   {31'h0, r[97]});
        check("valid_o",     {31'h0, valid},   {31'h0, r[96]});
        check("inst_o",      inst,             r[95:64]);
        check("pc_o",        pc_out,           r[63:32]);
        check("stall_cnt_o", stall_cnt,        r[31:0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 0; start = 0; flush = 0; id_stall = 0; mem_ack = 0;
    pc = 0; mem_data = 0;
    model_reset();
    do_reset();

    // Idle with start low: a stray ack must be ignored.
    cycle(0, 0, 0, 1, 32'h0, 32'hDEAD_0001);
    cycle(0, 0, 0, 1, 32'h0, 32'hDEAD_0002);

    // Zero-wait streaming, pc 0,4,8.
    cycle(1, 0, 0, 1, 32'h0, 32'hA000_0000);
    cycle(1, 0, 0, 1, 32'h0, 32'hA000_0000);
    cycle(1, 0, 0, 1, 32'h4, 32'hA000_0004);
    cycle(1, 0, 0, 1, 32'h8, 32'hA000_0008);

    // Three wait cycles at 0x10, then ack.
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 32'h10, 32'hBAD0_0000);
    cycle(1, 0, 0, 1, 32'h10, 32'hB000_0010);

    // Ack at 0x20 under decode stall, stall two cycles, then drain.
    cycle(1, 0, 1, 1, 32'h20, 32'hC000_0020);
    cycle(1, 0, 1, 1, 32'h24, 32'hBAD0_0024);
    cycle(1, 0, 0, 0, 32'h24, 32'hBAD0_0024);
    cycle(1, 0, 0, 1, 32'h24, 32'hC000_0024);

    // Flush coincident with ack, then flush while holding.
    cycle(1, 1, 0, 1, 32'h28, 32'hBAD0_0028);
    cycle(1, 0, 0, 1, 32'h40, 32'hD000_0040);
    cycle(1, 0, 1, 1, 32'h44, 32'hD000_0044);
    cycle(1, 1, 1, 0, 32'h48, 32'hBAD0_0048);
    cycle(1, 0, 0, 1, 32'h80, 32'hD000_0080);

    // start falling while holding: drain completes, then idle.
    cycle(1, 0, 1, 1, 32'h84, 32'hE000_0084);
    cycle(0, 0, 0, 1, 32'h88, 32'hBAD0_0088);
    cycle(0, 0, 0, 1, 32'h88, 32'hBAD0_0088);

    // Reset mid-wait.
    cycle(1, 0, 0, 0, 32'h90, 32'h0);
    cycle(1, 0, 0, 0, 32'h90, 32'h0);
    do_reset();

    // Five stall cycles after restart.
    cycle(1, 0, 0, 0, 32'h100, 32'h0);
    for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0, 32'h100, 32'h0);
    cycle(1, 0, 0, 1, 32'h100, 32'hF000_0100);
    cycle(1, 0, 0, 1, 32'h104, 32'hF000_0104);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 9) != 0,
            $urandom_range(0, 9) == 0,
            $urandom_range(0, 9) < 3,
            $urandom_range(0, 9) < 6,
            {$urandom_range(0, 255), 2'b00},
            $urandom);
    end

    @(negedge clk);
    #1;
    check("queue drained", exp_q.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_i  input  1  asynchronous active-low reset.
REQ-003 SHALL have port start_i  input  1  CPU run enable; low keeps the unit idle.
REQ-004 SHALL have port pc_i  input  32  current PC, driven by the PC register.
REQ-005 SHALL have port flush_i  input  1  branch/jump taken; discard fetch and IF/ID contents.
REQ-006 SHALL have port id_stall_i  input  1  decode-stage hazard stall; IF/ID must hold.
REQ-007 SHALL have port mem_req_o  output  1  instruction memory read request (level).
REQ-008 SHALL have port mem_addr_o  output  32  read address, equal to pc_i.
REQ-009 SHALL have port mem_ack_i  input  1  data valid for the current mem_addr_o; honoured only while mem_req_o=1.
REQ-010 SHALL have port mem_data_i  input  32  instruction word.
REQ-011 SHALL have port stall_o  output  1  PC hold, driving the PC register's select input.
REQ-012 SHALL have port inst_o  output  32  IF/ID instruction.
REQ-013 SHALL have port pc_o  output  32  IF/ID PC of inst_o.
REQ-014 SHALL have port valid_o  output  1  IF/ID holds a real instruction.
REQ-015 SHALL have port stall_cnt_o  output  32  fetch stall cycle count (see Configuration).

Function
REQ-016 SHALL implement the states IDLE, FETCH and HOLD.
REQ-017 IDLE: mem_req_o=0 and stall_o=0; moves to FETCH on the edge where start_i=1.
REQ-018 FETCH: mem_req_o=1 and mem_addr_o=pc_i, both combinational.
REQ-019 FETCH, ack=1, id_stall_i=0, flush_i=0: at the edge, inst_o<=mem_data_i, pc_o<=pc_i, valid_o<=1; stays in FETCH; one instruction per cycle with a zero-wait memory.
REQ-020 FETCH, ack=1, id_stall_i=1, flush_i=0: mem_data_i and pc_i go to a skid register; IF/ID holds; moves to HOLD.
REQ-021 FETCH, ack=0: IF/ID unchanged, except REQ-025 applies when flush_i=1.
REQ-022 HOLD: mem_req_o=0; on the first edge with id_stall_i=0, IF/ID<=skid, valid_o<=1, then moves to FETCH.
REQ-023 stall_o SHALL be combinational: 1 in FETCH when mem_ack_i=0, 1 in HOLD, else 0; forced to 0 when flush_i=1.
REQ-024 The PC therefore advances exactly once per acknowledged fetch.
REQ-025 flush_i=1 in any state: at the edge, valid_o<=0, inst_o<=32'h0 (NOP) and pc_o<=0; same-cycle ack data and the skid contents are discarded; next state is FETCH when start_i=1, else IDLE.
REQ-026 flush_i SHALL override id_stall_i.
REQ-027 start_i falling in FETCH: the current cycle completes per REQ-019/020, then the unit moves to IDLE; HOLD completes its drain first.
REQ-028 mem_ack_i while mem_req_o=0 SHALL be ignored.

Reset
REQ-029 rst_i=0 SHALL immediately force: state IDLE, inst_o=0, pc_o=0, valid_o=0, skid cleared, stall_cnt_o=0.
REQ-030 Reset mid-fetch SHALL abandon the request with no pending state.
REQ-031 The first fetch after reset release SHALL occur only after start_i=1.

Configuration
REQ-032 Macro IF_FETCH_STALL_CNT_EN defined: stall_cnt_o increments by 1 on each edge where stall_o=1 and the state is not IDLE, saturating at 32'hFFFFFFFF; flush does not clear it.
REQ-033 Macro IF_FETCH_STALL_CNT_EN undefined: stall_cnt_o is constant 0 and no counter logic exists; all other behaviour is identical.

Verification
REQ-034 Reset, start_i=1, zero-wait memory, pc_i stepping 0,4,8 -> inst_o/pc_o update every cycle, pc_o=0,4,8, stall_o=0 throughout.
REQ-035 mem_ack_i delayed 3 cycles at pc_i=0x10 -> stall_o=1 for 3 cycles, mem_addr_o stays 0x10, then inst_o=data and pc_o=0x10.
REQ-036 Ack at pc_i=0x20 with id_stall_i=1 for 2 cycles -> HOLD entered, mem_req_o=0, stall_o=1; on release pc_o=0x20 and the unit returns to FETCH.
REQ-037 flush_i=1 coincident with ack, and again in HOLD -> valid_o=0, inst_o=0, stall_o=0 that cycle, fetched data dropped.
REQ-038 rst_i low mid-wait, then released -> all outputs 0, state IDLE; with IF_FETCH_STALL_CNT_EN defined, 5 stall cycles give stall_cnt_o=5, and without the macro stall_cnt_o stays 0.
